// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word width, NOP encoding,
// default reset PC and fetch state encodings.
package instr_fetch_unit_pkg;

  localparam int          ILEN        = 32;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC selection: sequential pc+4 or word-aligned ALU target, plus misalign flag
// for a taken target whose low bits are non-zero.
module instr_fetch_unit_pc_next_sel
  import instr_fetch_unit_pkg::*;
(
  input  logic [ILEN-1:0] pc,
  input  logic            pc_sel,
  input  logic [ILEN-1:0] alu_target,
  output logic [ILEN-1:0] next_pc,
  output logic            misalign
);

  assign next_pc  = pc_sel ? {alu_target[ILEN-1:2], 2'b00} : pc + 32'd4;
  assign misalign = pc_sel && (alu_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, holds the fetched word for
// the decoder until acked, then advances the PC.
//
// state   | meaning
// FS_REQ  | request valid on imem_addr=pc, waiting for imem_req_ready
// FS_WAIT | request accepted, waiting for the response pulse
// FS_HOLD | instr/instr_pc live for the decoder, waiting for instr_ack
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_sel,
  input  logic [ILEN-1:0]  alu_target,
  input  logic             instr_ack,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [ILEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  output logic [ILEN-1:0]  instr,
  output logic [ILEN-1:0]  instr_pc,
  output logic             instr_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  fetch_state_t    state, state_nxt;
  logic [ILEN-1:0] pc;
  logic [ILEN-1:0] next_pc;
  logic            misalign;
  logic            retire;

  instr_fetch_unit_pc_next_sel u_pc_next_sel (
    .pc         (pc),
    .pc_sel     (pc_sel),
    .alu_target (alu_target),
    .next_pc    (next_pc),
    .misalign   (misalign)
  );

  assign imem_addr = pc;
  assign retire    = (state == FS_HOLD) && instr_ack;

  // REQ only hands off once the registered request is actually visible, so the
  // cycle right after reset never counts as an accepted request.
  always_comb begin
    state_nxt = state;
    case (state)
      FS_REQ:  if (imem_req_valid && imem_req_ready) state_nxt = FS_WAIT;
      FS_WAIT: if (imem_rsp_valid)                   state_nxt = FS_HOLD;
      FS_HOLD: if (instr_ack)                        state_nxt = FS_REQ;
      default:                                       state_nxt = FS_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FS_REQ;
      pc             <= RESET_PC;
      instr          <= RV_NOP;
      instr_pc       <= RESET_PC;
      instr_valid    <= 1'b0;
      imem_req_valid <= 1'b0;
      misalign_err   <= 1'b0;
      fetch_cnt      <= '0;
    end else begin
      state          <= state_nxt;
      imem_req_valid <= (state_nxt == FS_REQ);
      if ((state == FS_WAIT) && imem_rsp_valid) begin
        instr       <= imem_rsp_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
        fetch_cnt   <= fetch_cnt + CNT_W'(1);
        if (misalign) misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/ack timing compared against a PC/count model.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_sel = 1'b0;
  logic [31:0] alu_target = '0;
  logic        instr_ack = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;

  logic        imem_req_valid, instr_valid, misalign_err;
  logic [31:0] imem_addr, instr, instr_pc, fetch_cnt;
  logic        w_req_valid, w_instr_valid, w_misalign_err;
  logic [31:0] w_addr, w_instr, w_instr_pc, w_fetch_cnt;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .alu_target(alu_target),
    .instr_ack(instr_ack), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .alu_target(alu_target),
    .instr_ack(instr_ack), .imem_req_valid(w_req_valid),
    .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
    .misalign_err(w_misalign_err), .fetch_cnt(w_fetch_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc, m_pc_w, m_cnt;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles, input bit stale);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      pc_sel = 1'($urandom); alu_target = $urandom; instr_ack = 1'($urandom);
      imem_req_ready = 1'($urandom); imem_rsp_valid = 1'($urandom);
      imem_rsp_data = $urandom;
      @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);
      chk("rst_instr", instr, RV_NOP);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
    end
    rst = 1'b0;
    pc_sel = 1'b0; alu_target = '0; instr_ack = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = stale; imem_rsp_data = $urandom;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    m_pc = 32'h0; m_pc_w = 32'hFFFF_FFFC; m_cnt = 0; m_err = 1'b0;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_addr", imem_addr, m_pc);
    chk("first_addr_w", w_addr, m_pc_w);
    if (stale) begin
      chk("stale_instr_valid", 32'(instr_valid), 32'd0);
      chk("stale_instr", instr, RV_NOP);
    end
  endtask

  // Entered at a negedge with a request visible; leaves at the negedge after ack.
  task automatic do_instr(input int stall, input int rsp_lat, input int ack_lat,
                          input bit sel, input logic [31:0] tgt);
    logic [31:0] d;
    chk("req_addr", imem_addr, m_pc);
    chk("req_addr_w", w_addr, m_pc_w);
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0; imem_rsp_valid = 1'($urandom);
      instr_ack = 1'($urandom); pc_sel = 1'($urandom); alu_target = $urandom;
      @(negedge clk);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_addr", imem_addr, m_pc);
    end
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; instr_ack = 1'($urandom);
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < rsp_lat; i++) begin
      imem_rsp_valid = 1'b0; instr_ack = 1'($urandom); pc_sel = 1'($urandom);
      alu_target = $urandom;
      @(negedge clk);
      chk("wait_instr_valid", 32'(instr_valid), 32'd0);
    end
    d = $urandom;
    imem_rsp_valid = 1'b1; imem_rsp_data = d; instr_ack = 1'b0;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("hold_instr_valid", 32'(instr_valid), 32'd1);
    chk("hold_instr", instr, d);
    chk("hold_instr_pc", instr_pc, m_pc);
    for (int i = 0; i < ack_lat; i++) begin
      instr_ack = 1'b0; imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom;
      pc_sel = 1'($urandom); alu_target = $urandom;
      @(negedge clk);
      chk("hold_keep_instr", instr, d);
      chk("hold_req_valid", 32'(imem_req_valid), 32'd0);
    end
    instr_ack = 1'b1; pc_sel = sel; alu_target = tgt; imem_rsp_valid = 1'b0;
    @(negedge clk);
    instr_ack = 1'b0; pc_sel = 1'b0; alu_target = '0;
    m_pc   = sel ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
    m_pc_w = sel ? (tgt & 32'hFFFF_FFFC) : m_pc_w + 32'd4;
    m_cnt  = m_cnt + 1;
    if (sel && (tgt % 4 != 0)) m_err = 1'b1;
    chk("ack_instr_valid", 32'(instr_valid), 32'd0);
    chk("ack_req_valid", 32'(imem_req_valid), 32'd1);
    chk("next_addr", imem_addr, m_pc);
    chk("next_addr_w", w_addr, m_pc_w);
    chk("fetch_cnt", fetch_cnt, m_cnt);
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
  endtask

  initial begin
    // reset with random inputs, then four back-to-back fetches
    do_reset(3, 1'b0);
    for (int i = 0; i < 4; i++) do_instr(0, 0, 0, 1'b0, 32'h0);
    chk("seq_cnt4", fetch_cnt, 32'd4);
    chk("seq_addr", imem_addr, 32'h10);

    // backpressure at 0x4, branch from 0x8, misaligned target, sticky error
    do_reset(2, 1'b0);
    do_instr(0, 0, 0, 1'b0, 32'h0);
    do_instr(5, 0, 0, 1'b0, 32'h0);
    do_instr(0, 1, 2, 1'b1, 32'h100);
    chk("branch_addr", imem_addr, 32'h100);
    do_instr(0, 0, 0, 1'b1, 32'h102);
    chk("misalign_addr", imem_addr, 32'h100);
    chk("misalign_set", 32'(misalign_err), 32'd1);
    do_instr(2, 2, 1, 1'b0, 32'h0);
    chk("misalign_sticky", 32'(misalign_err), 32'd1);

    // reset while in WAIT with a stale response after release
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("pre_stale_wait", 32'(imem_req_valid), 32'd0);
    do_reset(2, 1'b1);

    // wrap from 0xFFFF_FFFC on the second instance
    do_instr(1, 0, 0, 1'b0, 32'h0);
    chk("wrap_addr_w", w_addr, 32'h0);

    // randomized timing and branches
    for (int i = 0; i < 25; i++) begin
      bit sel;
      sel = ($urandom_range(3) == 0);
      do_instr($urandom_range(3), $urandom_range(3), $urandom_range(3), sel, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
